// File: rtl/strassen_pkg.sv
// Shared types and constants for the Strassen 2x2 sequential multiplier.
// Signed mode is selected with the STRASSEN_SIGNED_EN macro.
package strassen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    HOLD
  } state_t;

  localparam logic [2:0] M1 = 3'd0;
  localparam logic [2:0] M2 = 3'd1;
  localparam logic [2:0] M3 = 3'd2;
  localparam logic [2:0] M4 = 3'd3;
  localparam logic [2:0] M5 = 3'd4;
  localparam logic [2:0] M6 = 3'd5;
  localparam logic [2:0] M7 = 3'd6;

  // Per-accumulator control: {enable, negate}
  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] ADD = 2'b10;
  localparam logic [1:0] SUB = 2'b11;

  // Accumulation table, fields packed as {C22,C21,C12,C11}
  function automatic logic [7:0] acc_ctl(input logic [2:0] idx);
    logic [7:0] r;
    case (idx)
      M1:      r = {ADD, NOP, NOP, ADD};
      M2:      r = {SUB, ADD, NOP, NOP};
      M3:      r = {ADD, NOP, ADD, NOP};
      M4:      r = {NOP, ADD, NOP, ADD};
      M5:      r = {NOP, NOP, ADD, SUB};
      M6:      r = {ADD, NOP, NOP, NOP};
      M7:      r = {NOP, NOP, NOP, ADD};
      default: r = {NOP, NOP, NOP, NOP};
    endcase
    return r;
  endfunction

  function automatic int ow(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/strassen_mul_pipe.sv
// Signed multiplier with LAT registered stages and a valid+tag sideband.
// Valid bits clear on reset so in-flight products are dropped.
module strassen_mul_pipe #(
  parameter int EW  = 18,
  parameter int LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [2:0]             in_tag,
  input  logic signed [EW-1:0]   x,
  input  logic signed [EW-1:0]   y,
  output logic                   out_valid,
  output logic [2:0]             out_tag,
  output logic signed [2*EW-1:0] p,
  output logic                   busy
);

  logic [LAT-1:0]          vld;
  logic [2:0]              tag  [LAT];
  logic signed [2*EW-1:0]  prod [LAT];
  logic signed [2*EW-1:0]  xe;
  logic signed [2*EW-1:0]  ye;

  assign xe = {{EW{x[EW-1]}}, x};
  assign ye = {{EW{y[EW-1]}}, y};

  // Valid shift register, cleared by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
    end else begin
      vld[0] <= in_valid;
      for (int i = 1; i < LAT; i++)
        vld[i] <= vld[i-1];
    end
  end

  // Product and tag stages
  always_ff @(posedge clk) begin
    tag[0]  <= in_tag;
    prod[0] <= xe * ye;
    for (int i = 1; i < LAT; i++) begin
      tag[i]  <= tag[i-1];
      prod[i] <= prod[i-1];
    end
  end

  assign out_valid = vld[LAT-1];
  assign out_tag   = tag[LAT-1];
  assign p         = prod[LAT-1];
  assign busy      = |vld;

endmodule

// File: rtl/strassen_seq_mac.sv
// Sequential 2x2 Strassen multiplier on one shared pipelined multiplier.
// Define STRASSEN_SIGNED_EN for two's complement operands and results.
module strassen_seq_mac
  import strassen_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int MUL_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4*WIDTH-1:0]         a_i,
  input  logic [4*WIDTH-1:0]         b_i,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [4*(2*WIDTH+1)-1:0]   c_o,
  output logic                       busy
);

  localparam int EW = WIDTH + 2;
  localparam int PW = 2 * EW;
  localparam int AW = 2 * WIDTH + 3;
  localparam int OW = ow(WIDTH);

`ifdef STRASSEN_SIGNED_EN
  function automatic logic signed [EW-1:0] ext(input logic [WIDTH-1:0] v);
    return {{2{v[WIDTH-1]}}, v};
  endfunction
`else
  function automatic logic signed [EW-1:0] ext(input logic [WIDTH-1:0] v);
    return {2'b00, v};
  endfunction
`endif

  state_t state_q;
  state_t state_d;
  logic [2:0]          k_q;
  logic [4*WIDTH-1:0]  a_q;
  logic [4*WIDTH-1:0]  b_q;
  logic signed [AW-1:0] acc [4];
  logic accept;
  logic issue;

  logic signed [EW-1:0] a11, a12, a21, a22;
  logic signed [EW-1:0] b11, b12, b21, b22;
  logic signed [EW-1:0] x, y;

  logic                 pv;
  logic [2:0]           ptag;
  logic signed [PW-1:0] p;
  logic                 pipe_busy;
  logic [7:0]           ctl;
  logic signed [AW-1:0] pe;
  logic                 unused_bits;

  assign a11 = ext(a_q[0*WIDTH +: WIDTH]);
  assign a12 = ext(a_q[1*WIDTH +: WIDTH]);
  assign a21 = ext(a_q[2*WIDTH +: WIDTH]);
  assign a22 = ext(a_q[3*WIDTH +: WIDTH]);
  assign b11 = ext(b_q[0*WIDTH +: WIDTH]);
  assign b12 = ext(b_q[1*WIDTH +: WIDTH]);
  assign b21 = ext(b_q[2*WIDTH +: WIDTH]);
  assign b22 = ext(b_q[3*WIDTH +: WIDTH]);

  assign accept = in_valid & in_ready;
  assign busy   = (state_q != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    issue     = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ISSUE;
      end
      ISSUE: begin
        issue = 1'b1;
        if (k_q == M7) state_d = DRAIN;
      end
      DRAIN: begin
        if (!pipe_busy) state_d = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Product counter and operand capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q <= '0;
      a_q <= '0;
      b_q <= '0;
    end else if (accept) begin
      k_q <= '0;
      a_q <= a_i;
      b_q <= b_i;
    end else if (issue) begin
      k_q <= k_q + 3'd1;
    end
  end

  // Operand pair for the product being issued
  always_comb begin
    x = '0;
    y = '0;
    case (k_q)
      M1: begin x = a11 + a22; y = b11 + b22; end
      M2: begin x = a21 + a22; y = b11;       end
      M3: begin x = a11;       y = b12 - b22; end
      M4: begin x = a22;       y = b21 - b11; end
      M5: begin x = a11 + a12; y = b22;       end
      M6: begin x = a21 - a11; y = b11 + b12; end
      M7: begin x = a12 - a22; y = b21 + b22; end
      default: begin x = '0; y = '0; end
    endcase
  end

  strassen_mul_pipe #(
    .EW  (EW),
    .LAT (MUL_LAT)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (issue),
    .in_tag    (k_q),
    .x         (x),
    .y         (y),
    .out_valid (pv),
    .out_tag   (ptag),
    .p         (p),
    .busy      (pipe_busy)
  );

  assign ctl = acc_ctl(ptag);
  assign pe  = p[AW-1:0];

  // Accumulate each returning product into its targets
  always_ff @(posedge clk) begin
    if (!rst_n || accept) begin
      for (int j = 0; j < 4; j++) acc[j] <= '0;
    end else if (pv) begin
      for (int j = 0; j < 4; j++) begin
        if (ctl[2*j+1])
          acc[j] <= ctl[2*j] ? acc[j] - pe : acc[j] + pe;
      end
    end
  end

  // Results are the low OW bits of each accumulator
  always_comb begin
    c_o = '0;
    for (int j = 0; j < 4; j++)
      c_o[j*OW +: OW] = acc[j][OW-1:0];
  end

  assign unused_bits = ^{p[PW-1:AW], acc[0][AW-1:OW], acc[1][AW-1:OW],
                         acc[2][AW-1:OW], acc[3][AW-1:OW]};

endmodule

// File: tb/tb_strassen_seq_mac.sv
// Scoreboard bench for strassen_seq_mac: directed tiles, stalls, reset
// abort and random tiles against a plain matrix-product model.
module tb_strassen_seq_mac;

  localparam int W   = 16;
  localparam int LAT = 2;
  localparam int OW  = 2 * W + 1;
  localparam int CW  = 4 * OW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [4*W-1:0] a_i;
  logic [4*W-1:0] b_i;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] c_o;
  logic          busy;

  int passed = 0;
  int total  = 0;
  logic [CW-1:0] sb [$];

  strassen_seq_mac #(
    .WIDTH   (W),
    .MUL_LAT (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_i       (a_i),
    .b_i       (b_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c_o       (c_o),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [CW-1:0] act,
                       input logic [CW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [4*W-1:0] pk(input int x22, input int x21,
                                        input int x12, input int x11);
    logic [W-1:0] e [4];
    e[0] = W'(x11); e[1] = W'(x12); e[2] = W'(x21); e[3] = W'(x22);
    return {e[3], e[2], e[1], e[0]};
  endfunction

  function automatic logic [CW-1:0] pc(input longint x22, input longint x21,
                                       input longint x12, input longint x11);
    logic [OW-1:0] e [4];
    e[0] = OW'(x11); e[1] = OW'(x12); e[2] = OW'(x21); e[3] = OW'(x22);
    return {e[3], e[2], e[1], e[0]};
  endfunction

  function automatic longint elem(input logic [4*W-1:0] m, input int i);
    logic [W-1:0] v;
    v = m[i*W +: W];
`ifdef STRASSEN_SIGNED_EN
    return longint'($signed(v));
`else
    return longint'(v);
`endif
  endfunction

  // Conventional row-by-column product
  function automatic logic [CW-1:0] model(input logic [4*W-1:0] a,
                                          input logic [4*W-1:0] b);
    longint c [4];
    for (int r = 0; r < 2; r++)
      for (int col = 0; col < 2; col++) begin
        c[2*r+col] = 0;
        for (int k = 0; k < 2; k++)
          c[2*r+col] += elem(a, 2*r+k) * elem(b, 2*k+col);
      end
    return pc(c[3], c[2], c[1], c[0]);
  endfunction

  task automatic wait_accept(output bit ok, output int n);
    ok = 0;
    n  = 0;
    while (!ok && n < 30) begin
      @(negedge clk);
      n++;
      ok = in_ready;
      @(posedge clk);
    end
  endtask

  task automatic run_tile(input logic [4*W-1:0] a, input logic [4*W-1:0] b,
                          input logic [CW-1:0] exp, input int stall);
    bit ok;
    int n;
    out_ready = (stall == 0);
    a_i = a;
    b_i = b;
    in_valid = 1'b1;
    wait_accept(ok, n);
    check("accept_wait", CW'(n), CW'(1));
    if (!ok) begin
      in_valid = 1'b0;
      return;
    end
    sb.push_back(exp);
    #1;
    in_valid = 1'b0;
    a_i = {$urandom, $urandom};
    b_i = {$urandom, $urandom};
    n = 0;
    ok = 0;
    while (!ok && n < 64) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      ok = out_valid;
    end
    check("latency", CW'(n), CW'(8 + LAT));
    if (!ok) begin
      out_ready = 1'b1;
      return;
    end
    for (int i = 0; i < stall; i++) begin
      check("hold_valid", CW'(out_valid), CW'(1));
      check("hold_in_ready", CW'(in_ready), CW'(0));
      check("hold_busy", CW'(busy), CW'(1));
      check("hold_c", c_o, exp);
      @(posedge clk);
      #1;
      if (i == stall - 1) out_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each delivered result with the oldest expectation
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", c_o, '0);
          if (c_o == '0) begin
            passed--;
            $display("FAIL unexpected_out: got result with empty scoreboard");
          end
        end else begin
          check("c_o", c_o, sb.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    int n;
    logic [4*W-1:0] ra, rb;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_i = '0;
    b_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", CW'(in_ready), CW'(1));
    check("rst_out_valid", CW'(out_valid), CW'(0));
    check("rst_c", c_o, '0);
    check("rst_busy", CW'(busy), CW'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Identity and small integer products
    run_tile(pk(4, 3, 2, 1), pk(1, 0, 0, 1), pc(4, 3, 2, 1), 0);
    run_tile(pk(4, 3, 2, 1), pk(8, 7, 6, 5), pc(50, 43, 22, 19), 0);

`ifdef STRASSEN_SIGNED_EN
    run_tile(pk(-1, -1, -1, -1), pk(2, 0, 0, 2),
             {4{33'h1_FFFF_FFFE}}, 0);
`else
    run_tile({4{16'hFFFF}}, {4{16'hFFFF}}, {4{33'h1_FFFC_0002}}, 0);
`endif

    // Back-pressure in HOLD, then immediate next tile
    run_tile(pk(4, 3, 2, 1), pk(8, 7, 6, 5), pc(50, 43, 22, 19), 5);
    run_tile(pk(1, 0, 0, 1), pk(9, 8, 7, 6), pc(9, 8, 7, 6), 0);

    // Reset during ISSUE at k=3
    a_i = pk(11, 12, 13, 14);
    b_i = pk(15, 16, 17, 18);
    in_valid = 1'b1;
    wait_accept(ok, n);
    check("rst_test_accept", CW'(ok), CW'(1));
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_out_valid", CW'(out_valid), CW'(0));
    check("abort_c", c_o, '0);
    check("abort_in_ready", CW'(in_ready), CW'(1));
    check("abort_busy", CW'(busy), CW'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_tile(pk(4, 3, 2, 1), pk(8, 7, 6, 5), pc(50, 43, 22, 19), 0);

    // Random tiles with random back-pressure
    for (int t = 0; t < 25; t++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      run_tile(ra, rb, model(ra, rb), int'($urandom_range(0, 3)));
    end

    repeat (4) @(posedge clk);
    check("sb_empty", CW'(sb.size()), CW'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
